// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin CPU/debug arbiter and fixed-latency sequencer for the unified memory
// Optional: define MEM_ARB_DBG_LOCK_EN to add DbgLock, which locks the CPU out of arbitration.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuAck,
  output logic [DW-1:0] CpuRData,
  output logic          CpuStall,
  input  logic          DbgReq,
  input  logic          DbgWe,
  input  logic [AW-1:0] DbgAddr,
  input  logic [DW-1:0] DbgWData,
  output logic          DbgAck,
  output logic [DW-1:0] DbgRData,
`ifdef MEM_ARB_DBG_LOCK_EN
  input  logic          DbgLock,
`endif
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       owner;     // 0 = CPU, 1 = debug
  logic       last_gnt;
  logic       we_q;
  logic [3:0] cnt;
  logic       cpu_elig;
  logic       grant;
  logic       gnt_sel;

`ifdef MEM_ARB_DBG_LOCK_EN
  assign cpu_elig = CpuReq & ~DbgLock;
`else
  assign cpu_elig = CpuReq;
`endif

  // Memory strobes and acks decode from state so a reset mid-access drops them at once.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_sel   = owner;
    MemEn     = 1'b0;
    MemWe     = 1'b0;
    CpuAck    = 1'b0;
    DbgAck    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_elig || DbgReq) begin
          grant     = 1'b1;
          gnt_sel   = (cpu_elig && DbgReq) ? ~last_gnt : DbgReq;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        MemEn = 1'b1;
        MemWe = we_q;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        CpuAck    = ~owner;
        DbgAck    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    CpuStall = CpuReq & ~CpuAck;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      CpuRData <= '0;
      DbgRData <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner    <= gnt_sel;
        last_gnt <= gnt_sel;
        cnt      <= CNT_INIT;
        we_q     <= gnt_sel ? DbgWe    : CpuWe;
        MemAddr  <= gnt_sel ? DbgAddr  : CpuAddr;
        MemWData <= gnt_sel ? DbgWData : CpuWData;
      end else if (state == BUSY) begin
        if (cnt == 4'd0) begin
          // Read data is only valid in the final busy cycle; writes keep the old RData.
          if (!we_q) begin
            if (owner) DbgRData <= MemRData;
            else       CpuRData <= MemRData;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (MEM_ARB_DBG_LOCK_EN adds the lock test)
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MEM_LAT = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          CpuReq = 1'b0, CpuWe = 1'b0;
  logic [AW-1:0] CpuAddr = '0;
  logic [DW-1:0] CpuWData = '0;
  logic          DbgReq = 1'b0, DbgWe = 1'b0;
  logic [AW-1:0] DbgAddr = '0;
  logic [DW-1:0] DbgWData = '0;
  logic          CpuAck, CpuStall, DbgAck, MemEn, MemWe;
  logic [DW-1:0] CpuRData, DbgRData, MemWData, MemRData;
  logic [AW-1:0] MemAddr;
`ifdef MEM_ARB_DBG_LOCK_EN
  logic          DbgLock = 1'b0;
`endif

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuRData(CpuRData), .CpuStall(CpuStall),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgAck(DbgAck), .DbgRData(DbgRData),
`ifdef MEM_ARB_DBG_LOCK_EN
    .DbgLock(DbgLock),
`endif
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // Behavioural memory seen by the DUT, and the reference image the model predicts from.
  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rd [2];
  assign MemRData = mem[MemAddr[5:2]];

  txn_t cpu_q[$], dbg_q[$];
  int   ack_port[$], ack_cyc[$];
  int   n_pass = 0, n_total = 0, cyc = 0, l0, l1, k;
  bit   prev_cpu, prev_dbg, prev_lock, m_last, m_owner, after_done, mem_init;
  int   en_cnt = 0;
  txn_t m_txn;
  logic [DW-1:0] m_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor and reference model: round robin over whoever was requesting in the idle cycle.
  always @(negedge Clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]     = 32'hC0DE_0000 | 32'(i * 17);
        ref_mem[i] = 32'hC0DE_0000 | 32'(i * 17);
      end
      mem[4]     = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;
      mem_init   = 1'b1;
    end
    cyc++;
    if (Reset) begin
      chk("rst_memen", MemEn, 0);
      chk("rst_memwe", MemWe, 0);
      chk("rst_acks", {CpuAck, DbgAck}, 0);
      chk("rst_stall", CpuStall, CpuReq);
      chk("rst_memaddr", MemAddr, 0);
      chk("rst_memwdata", MemWData, 0);
      chk("rst_rdata", {CpuRData, DbgRData}, 0);
      en_cnt = 0; m_last = 1'b1; after_done = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
    end else begin
      if (CpuAck) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
      if (DbgAck) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
      chk("cpu_stall", CpuStall, CpuReq & ~CpuAck);
      if (after_done) chk("idle_after_done", MemEn, 0);
      after_done = 1'b0;
      if (MemEn) begin
        if (en_cnt == 0) begin
          if (!(prev_cpu && !prev_lock) && !prev_dbg)
            $display("FAIL spurious_grant: access started with no eligible request");
          m_owner = (prev_cpu && !prev_lock && prev_dbg) ? !m_last : prev_dbg;
          m_last  = m_owner;
          if (m_owner ? (dbg_q.size() == 0) : (cpu_q.size() == 0)) begin
            n_total++;
            $display("FAIL grant_queue: owner %0d granted with empty queue", m_owner);
            m_txn = '0;
          end else begin
            m_txn = m_owner ? dbg_q[0] : cpu_q[0];
          end
          if (m_txn.we) begin
            ref_mem[m_txn.addr[5:2]] = m_txn.wdata;
            m_exp = last_rd[m_owner];
          end else begin
            m_exp = ref_mem[m_txn.addr[5:2]];
          end
        end
        en_cnt++;
        chk("busy_addr", MemAddr, m_txn.addr);
        chk("busy_we", MemWe, m_txn.we);
        if (m_txn.we) chk("busy_wdata", MemWData, m_txn.wdata);
        chk("busy_acks", {CpuAck, DbgAck}, 0);
        if (MemWe) mem[MemAddr[5:2]] = MemWData;
      end else if (en_cnt > 0) begin
        chk("busy_len", en_cnt, MEM_LAT);
        chk("done_acks", {CpuAck, DbgAck}, m_owner ? 2'b01 : 2'b10);
        chk("done_memwe", MemWe, 0);
        if (m_owner) chk("dbg_rdata", DbgRData, m_exp);
        else         chk("cpu_rdata", CpuRData, m_exp);
        last_rd[m_owner] = m_exp;
        if (m_owner && dbg_q.size() > 0) void'(dbg_q.pop_front());
        if (!m_owner && cpu_q.size() > 0) void'(cpu_q.pop_front());
        en_cnt = 0;
        after_done = 1'b1;
      end else begin
        chk("idle_acks", {CpuAck, DbgAck}, 0);
      end
    end
    prev_cpu = CpuReq;
    prev_dbg = DbgReq;
`ifdef MEM_ARB_DBG_LOCK_EN
    prev_lock = DbgLock;
`else
    prev_lock = 1'b0;
`endif
  end

  // Called just after a rising edge; returns just after the edge that ends the Ack cycle.
  task automatic do_access(input int p, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int lat);
    txn_t t;
    int n = 0;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (p == 0) begin
      CpuWe = we; CpuAddr = addr; CpuWData = wdata; CpuReq = 1'b1; cpu_q.push_back(t);
    end else begin
      DbgWe = we; DbgAddr = addr; DbgWData = wdata; DbgReq = 1'b1; dbg_q.push_back(t);
    end
    do begin
      @(negedge Clk);
      n++;
    end while (!((p == 0) ? CpuAck : DbgAck) && n < 400);
    if (n >= 400) begin
      n_total++;
      $display("FAIL ack_timeout: port %0d no ack after %0d cycles, expected within %0d", p, n, 400);
    end
    @(posedge Clk);
    #1;
    if (p == 0) CpuReq = 1'b0; else DbgReq = 1'b0;
    lat = n;
  endtask

  task automatic pulse_reset();
    @(negedge Clk); #2 Reset = 1'b1;
    @(negedge Clk); #2 Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    // Reset held with random request inputs.
    repeat (3) begin
      @(posedge Clk); #1;
      CpuReq = 1'($urandom); DbgReq = 1'($urandom);
      CpuWe = 1'($urandom); DbgWe = 1'($urandom);
      CpuAddr = $urandom; DbgAddr = $urandom;
    end
    CpuReq = 1'b0; DbgReq = 1'b0;
    @(negedge Clk); #2 Reset = 1'b0;
    @(posedge Clk); #1;

    do_access(0, 1'b0, 32'h10, '0, l0);
    chk("cpu_read_latency", l0, MEM_LAT + 2);
    chk("cpu_read_data", CpuRData, 32'hDEAD_BEEF);

    do_access(1, 1'b1, 32'h20, 32'h1234, l1);
    chk("dbg_write_latency", l1, MEM_LAT + 2);
    chk("dbg_rdata_unchanged", DbgRData, 0);
    chk("dbg_write_mem", mem[8], 32'h1234);

    // Both requesters continuously pulling after reset.
    pulse_reset();
    ack_port.delete(); ack_cyc.delete();
    fork
      for (int i = 0; i < 2; i++) do_access(0, 1'b0, 32'(i * 8), '0, l0);
      for (int i = 0; i < 2; i++) do_access(1, 1'b0, 32'(i * 8 + 4), '0, l1);
    join
    chk("rr_count", ack_port.size(), 4);
    if (ack_port.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", ack_port[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], MEM_LAT + 2);
    end

    // Reset in the first busy cycle of a CPU read.
    fork
      do_access(0, 1'b0, 32'h10, '0, l0);
    join_none
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!MemEn && k < 20);
    #1 Reset = 1'b1;
    #1 chk("abort_memen", MemEn, 0);
    chk("abort_acks", {CpuAck, DbgAck}, 0);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;
    wait fork;
    chk("abort_retry_data", CpuRData, 32'hDEAD_BEEF);

    // Randomised traffic from both ports.
    fork
      for (int i = 0; i < 30; i++) begin
        int gap = $urandom_range(0, 3);
        if (gap > 0) begin repeat (gap) @(posedge Clk); #1; end
        do_access(0, 1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, l0);
      end
      for (int i = 0; i < 30; i++) begin
        int gap = $urandom_range(0, 3);
        if (gap > 0) begin repeat (gap) @(posedge Clk); #1; end
        do_access(1, 1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, l1);
      end
    join

`ifdef MEM_ARB_DBG_LOCK_EN
    ack_port.delete(); ack_cyc.delete();
    DbgLock = 1'b1;
    fork
      do_access(0, 1'b0, 32'h10, '0, l0);
      begin
        for (int i = 0; i < 3; i++) do_access(1, 1'b0, 32'(i * 4), '0, l1);
        DbgLock = 1'b0;
      end
    join
    chk("lock_count", ack_port.size(), 4);
    if (ack_port.size() == 4)
      for (int i = 0; i < 4; i++) chk("lock_order", ack_port[i], (i < 3) ? 1 : 0);
`endif

    repeat (3) @(posedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    n_total++;
    $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 400000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
